game_timer_ctrl: RTL
====================

Name: game_timer_ctrl

Overview:
Countdown game timer controller for the sudoku board. It gates a cascaded decade prescaler, which counts 1 kHz tick pulses in groups of ten per stage. It runs a BCD mm:ss countdown from a player-selected minute limit and sequences it through idle, run, pause and expired states. It sits between the debounced button pulses and the 7-segment display / game-over logic.

Parameters:
DIV_STAGES, 3, number of cascaded divide-by-10 prescaler stages between tick_in and the 1 s tick (3 → 1 kHz to 1 Hz; 1..4 legal)
WARN_SEC, 10, remaining-seconds threshold (binary, 1..59) at or below which warn asserts in RUN/PAUSE

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
tick_in  in  1  base tick, one clk wide per pulse
start  in  1  one-clk pulse: begin countdown / resume / restart
pause  in  1  one-clk pulse: toggle RUN↔PAUSE
stop  in  1  one-clk pulse: abort to IDLE
lim_min  in  8  BCD minute limit {tens,ones}, sampled on start from IDLE or EXPIRED
min_bcd  out  8  remaining minutes, BCD {tens,ones}
sec_bcd  out  8  remaining seconds, BCD {tens,ones}
running  out  1  high in RUN
paused  out  1  high in PAUSE
warn  out  1  high in RUN/PAUSE when remaining total ≤ WARN_SEC s
expired  out  1  level, high in EXPIRED
timeout_pulse  out  1  one-clk pulse on entry to EXPIRED

Behaviour:
- Reset (rst=0 at posedge): state IDLE, all prescaler stages = 1, min_bcd=sec_bcd=8'h00, all flags 0. Reset overrides every input, including mid-countdown.
- States: IDLE, RUN, PAUSE, EXPIRED. Same-cycle command priority: stop > start > pause.
- IDLE: min_bcd follows the clamped lim_min each cycle; sec_bcd=00.
- IDLE + start: load min=clamped lim_min, sec=00, clear prescaler → RUN. If the clamped limit is 00 → EXPIRED instead.
- Clamping: any BCD digit of lim_min >9 is treated as 9.
- RUN + pause → PAUSE. PAUSE + pause or start → RUN. PAUSE holds the prescaler counts and the digits (no clear).
- Any state + stop → IDLE. The prescaler is cleared to 1 and digits follow the IDLE rule.
- EXPIRED: min/sec hold 00:00 and expired=1. Start → reload and run as from IDLE. Pause is ignored.
- Prescaler: each stage counts its input pulses 1..10. The 10th pulse emits one output pulse and resets the stage to 1. It advances only in RUN. A tick_in coincident with any state-changing command is ignored.
- The final-stage pulse is a registered sec_tick, high for one clk at the edge sampling the completing tick_in. The digits decrement on the next edge, i.e. 2 clks after the completing tick_in.
- Decrement sequence:
  - sec ones 0→9 with borrow; sec tens 0→5 with borrow; min ones 0→9 with borrow; min tens decrements.
  - The transition from 00:01 to 00:00 goes to EXPIRED on the same edge.
  - timeout_pulse is high for exactly the following cycle; expired is high from that cycle on.
- sec_tick pending at the moment of pause/stop is discarded.
- warn: combinational from state and digits. Remaining = min*60+sec ≤ WARN_SEC and state ∈ {RUN,PAUSE}.
- Outputs other than warn are registered. Digits are always valid BCD.

Test Plan:
1. DIV_STAGES=1, lim_min=8'h01, start, 10 tick_in pulses → min/sec go from 01:00 to 00:59 two clks after the 10th tick; running=1.
2. DIV_STAGES=1, lim_min=8'h01, start, 600 ticks → reads 00:00, timeout_pulse high exactly 1 clk, expired=1, running=0. Further ticks cause no change; warn rose when 00:10 was reached.
3. Run to 00:45 (lim 01), 4 ticks, pause, 20 ticks, pause, 6 ticks → paused=1 during the hold, display stays at 00:45, then reads 00:44 after resuming. This proves the prescaler state was held.
4. Simultaneous start+stop in RUN → IDLE, display shows lim_min:00. Pause+stop in PAUSE → IDLE.
5. lim_min=8'h00 then start → EXPIRED next cycle with one timeout_pulse. lim_min=8'hAF → loads 99:00.
6. rst=0 asserted mid-RUN at 00:37 → next cycle all outputs 0 and state IDLE. With rst=1 afterwards and no start, ticks do not change the digits.

Source files
------------

// File: rtl/game_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer_ctrl_if
//  Description : Command and display bundle for the countdown game timer.
//                master = button/tick source and display consumer side.
//                slave  = the timer controller.
//  Signals     : tick_in, start, pause, stop, lim_min  (master -> slave)
//                min_bcd, sec_bcd, running, paused, warn,
//                expired, timeout_pulse                (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface game_timer_ctrl_if;
  logic       tick_in;
  logic       start;
  logic       pause;
  logic       stop;
  logic [7:0] lim_min;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       paused;
  logic       warn;
  logic       expired;
  logic       timeout_pulse;

  modport master (
    output tick_in, start, pause, stop, lim_min,
    input  min_bcd, sec_bcd, running, paused, warn, expired, timeout_pulse
  );

  modport slave (
    input  tick_in, start, pause, stop, lim_min,
    output min_bcd, sec_bcd, running, paused, warn, expired, timeout_pulse
  );
endinterface
`default_nettype wire

// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer_ctrl
//  Description : BCD mm:ss countdown timer with a cascaded decade prescaler
//                (tick_in / 10^DIV_STAGES -> 1 s) and an IDLE/RUN/PAUSE/
//                EXPIRED sequencer.
//  Ports       : clk  - system clock
//                rst  - synchronous, active-low reset
//                bus  - game_timer_ctrl_if.slave (commands in, display and
//                       status flags out)
//  Parameters  : DIV_STAGES - number of divide-by-10 stages (1..4)
//                WARN_SEC   - remaining-seconds warning threshold (1..59)
//  Revision    : 1.0  initial release
// ============================================================================
module game_timer_ctrl #(
  parameter int DIV_STAGES = 3,
  parameter int WARN_SEC   = 10
) (
  input  wire logic           clk,
  input  wire logic           rst,
  game_timer_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_running;
  logic       r_paused;
  logic       r_expired;
  logic       r_timeout;
  logic       r_sec_tick;

  // --------------------------------------------------------------------------
  // Minute limit with each BCD digit saturated at 9
  // --------------------------------------------------------------------------
  logic [3:0] w_lim_tens;
  logic [3:0] w_lim_ones;
  logic [7:0] w_lim_clamped;
  logic       w_lim_zero;

  assign w_lim_tens    = (bus.lim_min[7:4] > 4'd9) ? 4'd9 : bus.lim_min[7:4];
  assign w_lim_ones    = (bus.lim_min[3:0] > 4'd9) ? 4'd9 : bus.lim_min[3:0];
  assign w_lim_clamped = {w_lim_tens, w_lim_ones};
  assign w_lim_zero    = (w_lim_clamped == 8'h00);

  // --------------------------------------------------------------------------
  // Prescaler. A tick only counts in RUN when no state-changing command
  // (stop or pause) arrives in the same cycle; start alone does nothing in RUN.
  // The chain is held at all-ones outside RUN/PAUSE so that every start
  // begins a full second.
  // --------------------------------------------------------------------------
  logic                  w_adv;
  logic                  w_pre_clr;
  logic [DIV_STAGES:0]   w_carry;

  assign w_adv      = (r_state == ST_RUN) && bus.tick_in && !bus.stop && !bus.pause;
  assign w_pre_clr  = (r_state == ST_IDLE) || (r_state == ST_EXPIRED) || bus.stop;
  assign w_carry[0] = w_adv;

  generate
    for (genvar gi = 0; gi < DIV_STAGES; gi++) begin : g_stage
      logic [3:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst || w_pre_clr) begin
          r_cnt <= 4'd1;
        end else if (w_carry[gi]) begin
          r_cnt <= (r_cnt == 4'd10) ? 4'd1 : r_cnt + 4'd1;
        end
      end

      assign w_carry[gi+1] = w_carry[gi] && (r_cnt == 4'd10);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // One-second BCD decrement with borrow ripple sec.ones -> sec.tens ->
  // min.ones -> min.tens
  // --------------------------------------------------------------------------
  logic [7:0] w_dec_min;
  logic [7:0] w_dec_sec;
  logic       w_last_sec;

  always_comb begin
    w_dec_min = r_min;
    w_dec_sec = r_sec;
    if (r_sec[3:0] != 4'd0) begin
      w_dec_sec[3:0] = r_sec[3:0] - 4'd1;
    end else begin
      w_dec_sec[3:0] = 4'd9;
      if (r_sec[7:4] != 4'd0) begin
        w_dec_sec[7:4] = r_sec[7:4] - 4'd1;
      end else begin
        w_dec_sec[7:4] = 4'd5;
        if (r_min[3:0] != 4'd0) begin
          w_dec_min[3:0] = r_min[3:0] - 4'd1;
        end else begin
          w_dec_min[3:0] = 4'd9;
          w_dec_min[7:4] = r_min[7:4] - 4'd1;
        end
      end
    end
  end

  assign w_last_sec = (r_min == 8'h00) && (r_sec == 8'h01);

  // --------------------------------------------------------------------------
  // Warning: with WARN_SEC below one minute the remaining total is within the
  // threshold only when the minutes are zero, so the seconds alone decide.
  // --------------------------------------------------------------------------
  logic [6:0] w_sec_bin;
  logic       w_warn;

  assign w_sec_bin = ({3'b000, r_sec[7:4]} * 7'd10) + {3'b000, r_sec[3:0]};
  assign w_warn    = ((r_state == ST_RUN) || (r_state == ST_PAUSE)) &&
                     (r_min == 8'h00) && (w_sec_bin <= 7'(WARN_SEC));

  // --------------------------------------------------------------------------
  // Sequencer with registered outputs. Priority stop > start > pause.
  // A pending sec_tick is only consumed in RUN without stop/pause, which
  // discards it whenever the countdown is paused or aborted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_min      <= 8'h00;
      r_sec      <= 8'h00;
      r_running  <= 1'b0;
      r_paused   <= 1'b0;
      r_expired  <= 1'b0;
      r_timeout  <= 1'b0;
      r_sec_tick <= 1'b0;
    end else begin
      r_timeout  <= 1'b0;
      r_sec_tick <= w_carry[DIV_STAGES];

      if (bus.stop) begin
        r_state   <= ST_IDLE;
        r_min     <= w_lim_clamped;
        r_sec     <= 8'h00;
        r_running <= 1'b0;
        r_paused  <= 1'b0;
        r_expired <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_EXPIRED: begin
            if (bus.start) begin
              r_sec    <= 8'h00;
              r_paused <= 1'b0;
              if (w_lim_zero) begin
                r_state   <= ST_EXPIRED;
                r_min     <= 8'h00;
                r_running <= 1'b0;
                r_expired <= 1'b1;
                r_timeout <= 1'b1;
              end else begin
                r_state   <= ST_RUN;
                r_min     <= w_lim_clamped;
                r_running <= 1'b1;
                r_expired <= 1'b0;
              end
            end else if (r_state == ST_IDLE) begin
              r_min <= w_lim_clamped;
              r_sec <= 8'h00;
            end
          end

          ST_RUN: begin
            if (bus.pause) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
              r_paused  <= 1'b1;
            end else if (r_sec_tick) begin
              if (w_last_sec) begin
                r_state   <= ST_EXPIRED;
                r_min     <= 8'h00;
                r_sec     <= 8'h00;
                r_running <= 1'b0;
                r_expired <= 1'b1;
                r_timeout <= 1'b1;
              end else begin
                r_min <= w_dec_min;
                r_sec <= w_dec_sec;
              end
            end
          end

          ST_PAUSE: begin
            if (bus.start || bus.pause) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
              r_paused  <= 1'b0;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.min_bcd       = r_min;
  assign bus.sec_bcd       = r_sec;
  assign bus.running       = r_running;
  assign bus.paused        = r_paused;
  assign bus.warn          = w_warn;
  assign bus.expired       = r_expired;
  assign bus.timeout_pulse = r_timeout;

endmodule
`default_nettype wire
